// File: rtl/barrel_pkg.sv
// barrel_pkg: shared operation type and elaboration helpers for the barrel shifter pipeline
package barrel_pkg;
  typedef enum logic [1:0] {ROT_UP, ROT_DOWN, SHIFT_UP, SHIFT_DOWN} shift_mode_t;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: a group of mux layers followed by an elastic valid/ready register slice
module barrel_stage import barrel_pkg::*; #(
  parameter int N           = 64,
  parameter int W           = 8,
  parameter int SW          = 6,
  parameter int FIRST_LAYER = 0,
  parameter int LAYERS      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [W-1:0]  in_data [0:N-1],
  input  logic [SW-1:0] in_amt,
  input  shift_mode_t   in_mode,
  input  logic [W-1:0]  in_fill,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [W-1:0]  out_data [0:N-1],
  output logic [SW-1:0] out_amt,
  output shift_mode_t   out_mode,
  output logic [W-1:0]  out_fill
);
  logic [W-1:0] mux [0:LAYERS][0:N-1];
  logic [W-1:0] data_d [0:N-1];
  logic [W-1:0] data_q [0:N-1];
  logic [SW-1:0] amt_d, amt_q;
  logic [W-1:0] fill_d, fill_q;
  shift_mode_t mode_d, mode_q;
  logic valid_d, valid_q;
  logic in_ready, load;
  for (genvar j = 0; j < N; j++) begin : g_in
    assign mux[0][j] = in_data[j];
  end
  // Layer l moves elements by 2^(FIRST_LAYER+l) when that amount bit is set
  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    localparam int D = 1 << (FIRST_LAYER + l);
    for (genvar j = 0; j < N; j++) begin : g_elem
      localparam int UP = (j + N - D) % N;
      localparam int DN = (j + D) % N;
      assign mux[l+1][j] = !in_amt[FIRST_LAYER+l] ? mux[l][j] :
                           in_mode == ROT_UP   ? mux[l][UP] :
                           in_mode == ROT_DOWN ? mux[l][DN] :
                           in_mode == SHIFT_UP ? ((j >= D) ? mux[l][UP] : in_fill) :
                           ((j + D < N) ? mux[l][DN] : in_fill);
    end
  end
  assign in_ready = !valid_q || out_ready;
  assign load     = in_valid && in_ready;
  always_comb begin
    valid_d = in_ready ? in_valid : valid_q;
    amt_d   = load ? in_amt : amt_q;
    mode_d  = load ? in_mode : mode_q;
    fill_d  = load ? in_fill : fill_q;
    for (int j = 0; j < N; j++) data_d[j] = load ? mux[LAYERS][j] : data_q[j];
  end
  always_ff @(posedge clk) begin
    valid_q <= rst ? 1'b0 : valid_d;
    amt_q   <= rst ? '0 : amt_d;
    mode_q  <= rst ? ROT_UP : mode_d;
    fill_q  <= rst ? '0 : fill_d;
    for (int j = 0; j < N; j++) data_q[j] <= rst ? '0 : data_d[j];
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_amt   = amt_q;
  assign out_mode  = mode_q;
  assign out_fill  = fill_q;
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: elastic pipelined vector rotator/shifter with per-item amount, mode and fill
module barrel_shift_pipe import barrel_pkg::*; #(
  parameter int NUM_ELEMS        = 64,
  parameter int DATA_WIDTH       = 8,
  parameter int SHIFT_WIDTH      = $clog2(NUM_ELEMS),
  parameter int LAYERS_PER_STAGE = 1,
  localparam int NUM_LAYERS      = log2(NUM_ELEMS),
  localparam int NUM_STAGES      = (NUM_LAYERS + LAYERS_PER_STAGE - 1) / LAYERS_PER_STAGE,
  localparam int CNT_WIDTH       = $clog2(NUM_STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ip1 [0:NUM_ELEMS-1],
  input  logic [SHIFT_WIDTH-1:0] amt,
  input  shift_mode_t            mode,
  input  logic [DATA_WIDTH-1:0]  fill,
  input  logic                   start,
  output logic                   rdy,
  output logic [DATA_WIDTH-1:0]  op [0:NUM_ELEMS-1],
  output logic                   valid,
  input  logic                   ack,
  output logic [CNT_WIDTH-1:0]   in_flight
);
  logic [NUM_STAGES:0] valid_v;
  logic [NUM_STAGES:0] ready_v;
  logic [DATA_WIDTH-1:0] data_c [0:NUM_STAGES][0:NUM_ELEMS-1];
  logic [SHIFT_WIDTH-1:0] amt_c [0:NUM_STAGES];
  shift_mode_t mode_c [0:NUM_STAGES];
  logic [DATA_WIDTH-1:0] fill_c [0:NUM_STAGES];
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic in_x, out_x;
  assign valid_v[0]          = start && !rst;
  assign ready_v[NUM_STAGES] = ack;
  assign amt_c[0]            = amt;
  assign mode_c[0]           = mode;
  assign fill_c[0]           = fill;
  for (genvar j = 0; j < NUM_ELEMS; j++) begin : g_ip
    assign data_c[0][j] = ip1[j];
  end
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int FIRST  = s * LAYERS_PER_STAGE;
    localparam int LAYERS = (NUM_LAYERS - FIRST < LAYERS_PER_STAGE) ? NUM_LAYERS - FIRST : LAYERS_PER_STAGE;
    // Stage s can take data unless it and every stage after it is full and ack is low
    assign ready_v[s] = ack || !(&valid_v[NUM_STAGES:s+1]);
    barrel_stage #(
      .N(NUM_ELEMS), .W(DATA_WIDTH), .SW(SHIFT_WIDTH), .FIRST_LAYER(FIRST), .LAYERS(LAYERS)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid_v[s]),
      .in_data   (data_c[s]),
      .in_amt    (amt_c[s]),
      .in_mode   (mode_c[s]),
      .in_fill   (fill_c[s]),
      .out_ready (ready_v[s+1]),
      .out_valid (valid_v[s+1]),
      .out_data  (data_c[s+1]),
      .out_amt   (amt_c[s+1]),
      .out_mode  (mode_c[s+1]),
      .out_fill  (fill_c[s+1])
    );
  end
  assign rdy   = ready_v[0] && !rst;
  assign valid = valid_v[NUM_STAGES];
  assign op    = data_c[NUM_STAGES];
  always_comb begin
    in_x  = start && rdy;
    out_x = valid && ack;
    cnt_d = (in_x && !out_x) ? cnt_q + CNT_WIDTH'(1) :
            (out_x && !in_x) ? cnt_q - CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign in_flight = cnt_q;
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed and randomized checks of the barrel shifter at 1, 2 and 3 layers per stage
module tb_barrel_shift_pipe;
  import barrel_pkg::*;
  typedef logic [7:0] vec_t [0:7];
  logic clk = 0, rst = 1, start = 0, ack = 1;
  vec_t ip1, op1, op2, op3;
  logic [2:0] amt = 0;
  shift_mode_t mode = ROT_UP;
  logic [7:0] fill = 0;
  logic rdy1, rdy2, rdy3, valid1, valid2, valid3;
  logic [1:0] inf1, inf2;
  logic inf3;
  int checks = 0, errors = 0;
  logic [63:0] q2 [$], q3 [$];
  int n2 = 0, n3 = 0;
  always #5 clk = ~clk;
  barrel_shift_pipe #(.NUM_ELEMS(8), .DATA_WIDTH(8), .LAYERS_PER_STAGE(1)) dut (
    .clk(clk), .rst(rst), .ip1(ip1), .amt(amt), .mode(mode), .fill(fill), .start(start),
    .rdy(rdy1), .op(op1), .valid(valid1), .ack(ack), .in_flight(inf1));
  barrel_shift_pipe #(.NUM_ELEMS(8), .DATA_WIDTH(8), .LAYERS_PER_STAGE(2)) dut2 (
    .clk(clk), .rst(rst), .ip1(ip1), .amt(amt), .mode(mode), .fill(fill), .start(start),
    .rdy(rdy2), .op(op2), .valid(valid2), .ack(ack), .in_flight(inf2));
  barrel_shift_pipe #(.NUM_ELEMS(8), .DATA_WIDTH(8), .LAYERS_PER_STAGE(3)) dut3 (
    .clk(clk), .rst(rst), .ip1(ip1), .amt(amt), .mode(mode), .fill(fill), .start(start),
    .rdy(rdy3), .op(op3), .valid(valid3), .ack(ack), .in_flight(inf3));
  function automatic logic [63:0] pk(input vec_t v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[63-8*i -: 8] = v[i];
    return r;
  endfunction
  function automatic logic [63:0] model(input vec_t v, input int k, input shift_mode_t m, input logic [7:0] f);
    vec_t r;
    for (int j = 0; j < 8; j++)
      case (m)
        ROT_UP:   r[j] = v[(j - k + 8) % 8];
        ROT_DOWN: r[j] = v[(j + k) % 8];
        SHIFT_UP: r[j] = (j >= k) ? v[j - k] : f;
        default:  r[j] = (j + k < 8) ? v[j + k] : f;
      endcase
    return pk(r);
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic vsel(input int s);
    return s == 1 ? valid1 : s == 2 ? valid2 : valid3;
  endfunction
  function automatic logic [63:0] osel(input int s);
    return s == 1 ? pk(op1) : s == 2 ? pk(op2) : pk(op3);
  endfunction
  task automatic one(input int sel, input logic [2:0] k, input shift_mode_t m, input logic [7:0] f,
                     input logic [63:0] exp, input int lat_exp, input string tag);
    int lat;
    amt = k; mode = m; fill = f; start = 1; ack = 1;
    @(posedge clk);
    #1 start = 0;
    lat = 1;
    while (vsel(sel) !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    chk(tag, osel(sel), exp);
    step();
    chk({tag, "_once"}, 64'(vsel(sel)), 64'd0);
  endtask
  task automatic rnd_cycle(input bit drive);
    if (drive) begin
      for (int j = 0; j < 8; j++) ip1[j] = 8'($urandom);
      amt = 3'($urandom); mode = shift_mode_t'($urandom_range(0, 3)); fill = 8'($urandom);
      start = $urandom_range(0, 3) != 0; ack = $urandom_range(0, 3) != 0;
    end else begin
      start = 0; ack = 1;
    end
    #1;
    chk("rnd_inflight2", 64'(inf2), 64'(q2.size()));
    chk("rnd_inflight3", 64'(inf3), 64'(q3.size()));
    if (valid2 && ack) begin
      n2++;
      chk("rnd_op2", pk(op2), q2.size() != 0 ? q2.pop_front() : 'x);
    end
    if (valid3 && ack) begin
      n3++;
      chk("rnd_op3", pk(op3), q3.size() != 0 ? q3.pop_front() : 'x);
    end
    if (start && rdy2) q2.push_back(model(ip1, amt, mode, fill));
    if (start && rdy3) q3.push_back(model(ip1, amt, mode, fill));
    step();
  endtask
  initial begin
    int acc;
    for (int j = 0; j < 8; j++) ip1[j] = 8'(j + 1);
    step(); step();
    chk("rdy_in_rst", 64'(rdy1), 64'd0);
    rst = 0;
    #1;
    chk("rdy_after_rst", 64'(rdy1), 64'd1);
    chk("valid_rst", 64'(valid1), 64'd0);
    chk("inflight_rst", 64'(inf1), 64'd0);
    chk("op_rst", pk(op1), 64'd0);
    one(1, 3'd3, ROT_UP, 8'h00, 64'h0607080102030405, 3, "rot_up3");
    one(1, 3'd3, ROT_DOWN, 8'h00, 64'h0405060708010203, 3, "rot_down3");
    one(1, 3'd2, SHIFT_UP, 8'hAA, 64'hAAAA010203040506, 3, "shift_up2");
    one(1, 3'd5, SHIFT_DOWN, 8'h00, 64'h0607080000000000, 3, "shift_down5");
    for (int m = 0; m < 4; m++) one(1, 3'd0, shift_mode_t'(m), 8'h55, 64'h0102030405060708, 3, "amt0");
    mode = ROT_UP; fill = 0; ack = 1;
    for (int c = 0; c < 11; c++) begin
      start = c < 8;
      amt = 3'(c);
      if (c < 8) chk("stream_rdy", 64'(rdy1), 64'd1);
      step();
      if (c >= 2 && c <= 9) begin
        chk("stream_valid", 64'(valid1), 64'd1);
        chk("stream_op", pk(op1), model(ip1, c - 2, ROT_UP, 8'h00));
      end
      if (c >= 2 && c <= 7) chk("stream_inflight", 64'(inf1), 64'd3);
      if (c == 10) chk("stream_end", 64'(valid1), 64'd0);
    end
    ack = 0; start = 1; acc = 0;
    for (int c = 0; c < 5; c++) begin
      amt = 3'(acc + 1);
      if (rdy1) acc++;
      step();
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    chk("bp_rdy", 64'(rdy1), 64'd0);
    chk("bp_inflight", 64'(inf1), 64'd3);
    chk("bp_valid", 64'(valid1), 64'd1);
    chk("bp_op", pk(op1), model(ip1, 1, ROT_UP, 8'h00));
    step();
    chk("bp_hold", pk(op1), model(ip1, 1, ROT_UP, 8'h00));
    amt = 3'd4; ack = 1;
    #1;
    chk("bp_pulse_rdy", 64'(rdy1), 64'd1);
    step();
    start = 0;
    chk("bp_pulse_inflight", 64'(inf1), 64'd3);
    chk("bp_pulse_op", pk(op1), model(ip1, 2, ROT_UP, 8'h00));
    for (int k = 3; k <= 4; k++) begin
      step();
      chk("bp_drain_op", pk(op1), model(ip1, k, ROT_UP, 8'h00));
    end
    step();
    chk("bp_drain_valid", 64'(valid1), 64'd0);
    chk("bp_drain_inflight", 64'(inf1), 64'd0);
    ack = 1; start = 1; amt = 3'd1;
    step();
    amt = 3'd2;
    step();
    start = 0;
    chk("rst_pre_inflight", 64'(inf1), 64'd2);
    rst = 1;
    step();
    rst = 0;
    chk("rst_valid", 64'(valid1), 64'd0);
    chk("rst_inflight", 64'(inf1), 64'd0);
    chk("rst_op", pk(op1), 64'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rst_no_stale", 64'(valid1), 64'd0);
    end
    one(2, 3'd3, ROT_UP, 8'h00, 64'h0607080102030405, 2, "lps2_rot_up3");
    one(2, 3'd6, SHIFT_UP, 8'hAA, 64'hAAAAAAAAAAAA0102, 2, "lps2_shift_up6");
    one(3, 3'd5, SHIFT_DOWN, 8'h00, 64'h0607080000000000, 1, "lps3_shift_down5");
    one(3, 3'd7, ROT_DOWN, 8'h00, 64'h0801020304050607, 1, "lps3_rot_down7");
    for (int c = 0; c < 4; c++) step();
    for (int c = 0; c < 20000 && (n2 < 1000 || n3 < 1000); c++) rnd_cycle(1);
    for (int c = 0; c < 4; c++) rnd_cycle(0);
    chk("rnd_count2", 64'(n2 >= 1000), 64'd1);
    chk("rnd_count3", 64'(n3 >= 1000), 64'd1);
    chk("rnd_drained2", 64'(q2.size()), 64'd0);
    chk("rnd_drained3", 64'(q3.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
Parametrised, elastic successor to the team's pipelined element rotator: shifts or rotates a NUM_ELEMS-element vector by a per-transaction amount, in one of four modes. The log2(NUM_ELEMS) mux layers are grouped into register stages, with a configurable number of layers per stage. Each stage has a valid/ready handshake, so there are no bubbles and full throughput under backpressure. It sits between vector producers and consumers in the datapath and uses the same start/rdy/valid/ack protocol.

Parameters:
NUM_ELEMS, 64, vector length; power of two, >=2
DATA_WIDTH, 8, bits per element
SHIFT_WIDTH, $clog2(NUM_ELEMS), shift-amount width
LAYERS_PER_STAGE, 1, mux layers between pipeline registers; 1..NUM_LAYERS
(derived) NUM_LAYERS = log2(NUM_ELEMS); NUM_STAGES = ceil(NUM_LAYERS/LAYERS_PER_STAGE); CNT_WIDTH = $clog2(NUM_STAGES+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ip1  in  [DATA_WIDTH-1:0] x [0:NUM_ELEMS-1]  input vector
amt  in  SHIFT_WIDTH  shift/rotate amount
mode  in  2  shift_mode_t operation
fill  in  DATA_WIDTH  fill element for shift modes
start  in  1  input valid
rdy  out  1  input ready
op  out  [DATA_WIDTH-1:0] x [0:NUM_ELEMS-1]  result vector
valid  out  1  output valid
ack  in  1  downstream ready
in_flight  out  CNT_WIDTH  number of occupied stages

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset: all stage valids = 0; valid = 0; op = all zeros; in_flight = 0; rdy = 1 in the cycle after reset deasserts. While rst is high, rdy = 0.
- Input transfer: start && rdy on a rising clk edge. Output transfer: valid && ack.
- Modes (amt = k, N = NUM_ELEMS):
  - ROT_UP (0): op[j] = ip1[(j-k) mod N].
  - ROT_DOWN (1): op[j] = ip1[(j+k) mod N].
  - SHIFT_UP (2): op[j] = (j>=k) ? ip1[j-k] : fill.
  - SHIFT_DOWN (3): op[j] = (j+k<N) ? ip1[j+k] : fill.
- k = 0 passes the vector through in every mode.
- Layer i acts on amt bit i (distance 2^i).
- amt, mode and fill are captured with the data at input transfer and travel with it through every stage. Later changes on the inputs never affect an accepted item.
- Stage s holds a data register and a valid bit.
  - ready_s = !valid_s || ready_(s+1), where ready_NUM_STAGES = ack.
  - rdy = ready_0. The ready chain is combinational.
- Latency: an item accepted at edge t presents valid at edge t+NUM_STAGES if there is no stall. Throughput is 1 item/cycle with ack held high.
- Stall: when ack = 0 and the pipe is full, every stage holds its value. rdy = 0 after NUM_STAGES items are accepted.
- A full pipe with ack = 1 and start = 1 advances and accepts in the same cycle; no bubble.
- The op/valid registers are stage NUM_STAGES-1. op holds its value while valid && !ack. op is don't-care (no change required) while valid = 0.
- in_flight: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur. Range 0..NUM_STAGES. It must equal the popcount of the stage valids.
- Reset mid-operation: all in-flight items are discarded with no output.

Decomposition:
- Package barrel_pkg:
  - typedef enum logic [1:0] shift_mode_t {ROT_UP, ROT_DOWN, SHIFT_UP, SHIFT_DOWN}
  - log2 helper function
- Sub-module barrel_stage, parameters FIRST_LAYER and LAYERS:
  - combinational mux layers FIRST_LAYER..FIRST_LAYER+LAYERS-1
  - carries amt, mode and fill through to the next stage
  - contains its own valid/ready register slice
- barrel_shift_pipe instantiates NUM_STAGES barrel_stage with a generate loop and owns the in_flight counter.

Test Plan:
Configuration for every scenario: NUM_ELEMS=8, DATA_WIDTH=8, LAYERS_PER_STAGE=1 (3 stages); ip1[j] = j+1, listed as index 0..7.
1. Rotate, both directions.
   - ROT_UP, amt=3, ack=1 -> after 3 cycles op = 6,7,8,1,2,3,4,5, valid for 1 cycle.
   - ROT_DOWN, amt=3 -> op = 4,5,6,7,8,1,2,3.
2. Shift, both directions.
   - SHIFT_UP, amt=2, fill=0xAA -> op = AA,AA,1,2,3,4,5,6.
   - SHIFT_DOWN, amt=5, fill=0 -> op = 6,7,8,0,0,0,0,0.
   - Any mode with amt=0 -> op = 1..8.
3. Streaming: 8 back-to-back items with amt 0..7 in ROT_UP, ack=1.
   - rdy is high throughout.
   - Outputs appear on 8 consecutive cycles in order, each matching the reference model.
   - in_flight stays at 3 in steady state.
4. Backpressure.
   - ack=0, start=1 for 5 cycles -> exactly 3 items accepted, rdy=0 afterwards, in_flight=3, op stable.
   - Pulse ack for 1 cycle -> item 1 leaves, item 4 is accepted in the same cycle, in_flight stays at 3.
5. Reset mid-stream: assert rst for 1 cycle with in_flight=2 -> next cycle valid=0, in_flight=0, op=0; no stale item ever emerges.
6. Parameter sweep: LAYERS_PER_STAGE = 2 and 3 (2 and 1 stages).
   - Latency equals NUM_STAGES.
   - Random mode/amt/fill/ack run over 1000 items matches the model.
